// File: rtl/uart_rx_fifo_if.sv
// Host read port of the UART receiver.
//
// Handshake: r_data holds the FIFO head word and is valid whenever
// rx_empty=0. The host consumes that word by holding rd_uart high for one
// clk while rx_empty=0. rd_uart while rx_empty=1 is ignored.
// frame_err and overrun are one-cycle status pulses from the receiver.
//
// Signals:
//   rd_uart   host -> rx   pop request
//   r_data    rx -> host   FIFO head word (first-word-fallthrough)
//   rx_empty  rx -> host   FIFO empty
//   rx_full   rx -> host   FIFO full
//   frame_err rx -> host   stop bit sampled low, word discarded
//   overrun   rx -> host   word arrived while FIFO full, word dropped
interface uart_rx_fifo_if #(
  parameter int DBIT = 8
);
  logic            rd_uart;
  logic [DBIT-1:0] r_data;
  logic            rx_empty;
  logic            rx_full;
  logic            frame_err;
  logic            overrun;

  modport master (
    output rd_uart,
    input  r_data,
    input  rx_empty,
    input  rx_full,
    input  frame_err,
    input  overrun
  );

  modport slave (
    input  rd_uart,
    output r_data,
    output rx_empty,
    output rx_full,
    output frame_err,
    output overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive path: 2-flop synchronizer on rx, 16x oversampling deframer
// for 8N1-style characters, and a small first-word-fallthrough FIFO that
// feeds the host read port.
//
// Ports:
//   clk       system clock, all logic on posedge
//   reset     asynchronous, active-high reset
//   rx        serial line, idle high, asynchronous to clk
//   host      read port (slave side of uart_rx_fifo_if)
//   dbg_state current deframer state (0 IDLE, 1 START, 2 DATA, 3 STOP)
module uart_rx_fifo #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163,
  parameter int FIFO_W  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  uart_rx_fifo_if.slave      host,
  output logic [1:0]         dbg_state
);

  localparam int CW    = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
  // s is 4 bits for the usual 16-tick stop bit; it widens so that 1.5 and
  // 2 stop bits (24 / 32 ticks) can still be counted.
  localparam int SW    = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int DEPTH = 2 ** FIFO_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Oversampling tick: one-clk pulse every DVSR clocks
  // ---------------------------------------------------------------------
  logic [CW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == CW'(DVSR - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // rx synchronizer; resets to the idle level so reset never looks like a
  // start bit
  // ---------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------
  // Deframer FSM
  // ---------------------------------------------------------------------
  state_t          state, state_next;
  logic [SW-1:0]   s, s_next;
  logic [NW-1:0]   n, n_next;
  logic [DBIT-1:0] b, b_next;
  logic            stop_sample;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
    end else begin
      state <= state_next;
      s     <= s_next;
      n     <= n_next;
      b     <= b_next;
    end
  end

  always_comb begin
    state_next  = state;
    s_next      = s;
    n_next      = n;
    b_next      = b;
    stop_sample = 1'b0;
    case (state)
      IDLE: begin
        // Falling edge detection needs no tick; s restarts so the mid-start
        // check lands 8 ticks later.
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s == SW'(7)) begin
            if (!rx_s) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              // Line went high again before mid start bit: a glitch.
              state_next = IDLE;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == SW'(15)) begin
            s_next = '0;
            b_next = {rx_s, b[DBIT-1:1]};
            n_next = n + 1'b1;
            if (n == NW'(DBIT - 1)) begin
              state_next = STOP;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s == SW'(SB_TICK - 1)) begin
            stop_sample = 1'b1;
            state_next  = IDLE;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign dbg_state = state;

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  logic [DBIT-1:0]   mem [DEPTH];
  logic [FIFO_W-1:0] wptr, rptr, wptr_succ, rptr_succ;
  logic              full, empty;
  logic              push_req, pop, push_ok, drop;
  logic              frame_err_q, overrun_q;

  assign push_req  = stop_sample & rx_s;
  assign pop       = host.rd_uart & ~empty;
  // A simultaneous pop frees the slot the push needs, so a full FIFO only
  // drops the word when nobody is reading in that cycle.
  assign push_ok   = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;
  assign wptr_succ = wptr + 1'b1;
  assign rptr_succ = rptr + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wptr] <= b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      case ({push_ok, pop})
        2'b10: begin
          wptr  <= wptr_succ;
          empty <= 1'b0;
          full  <= (wptr_succ == rptr);
        end
        2'b01: begin
          rptr  <= rptr_succ;
          full  <= 1'b0;
          empty <= (rptr_succ == wptr);
        end
        2'b11: begin
          wptr <= wptr_succ;
          rptr <= rptr_succ;
        end
        default: ;
      endcase
    end
  end

  // Status pulses are registered so they line up with the FIFO flag update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_sample & ~rx_s;
      overrun_q   <= drop;
    end
  end

  assign host.r_data    = mem[rptr];
  assign host.rx_empty  = empty;
  assign host.rx_full   = full;
  assign host.frame_err = frame_err_q;
  assign host.overrun   = overrun_q;

endmodule
